ahb_bram_ctrl: RTL and testbench

AHB-Lite slave that fronts the dual-port code/data block RAM for the Cortex-M0 bus. It is the initiator side of the RAM interface. It turns AHB address and data phases into RAM write-port strobes (word address, data, 4-bit byte enable) and read-port addresses, and returns read data with zero wait states. It also forwards pending write data into a back-to-back read of the same word, and generates the two-cycle AHB ERROR response for illegal sizes or misalignment.

---
 rtl/ahb_bram_ctrl.sv | 139 +++++++++++++
 tb/tb_ahb_bram_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a dual-port block RAM: zero-wait-state reads and writes,
// write-to-read forwarding for back-to-back accesses, and a two-cycle ERROR response.
module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [31:0]           dina,
  output logic [3:0]            wea,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [31:0]           doutb
);

  typedef enum logic [1:0] {
    RESP_OKAY,
    RESP_ERR1,
    RESP_ERR2
  } resp_state_t;

  resp_state_t state, state_nxt;

  logic                  accept;
  logic                  illegal;
  logic                  acc_wr;
  logic                  acc_rd;
  logic [3:0]            mask;
  logic [ADDR_WIDTH-1:0] haddr_word;

  logic                  wr_dp;
  logic                  rd_dp;
  logic                  fwd;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]            wr_mask;
  logic [3:0]            fwd_mask;
  logic [31:0]           fwd_data;

  // Address bits above the decoded RAM window and the SEQ/NONSEQ distinction are ignored.
  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign haddr_word = HADDR[ADDR_WIDTH+1:2];
  assign accept     = HSEL & HTRANS[1] & HREADY;
  assign acc_wr     = accept & ~illegal & HWRITE;
  assign acc_rd     = accept & ~illegal & ~HWRITE;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mask    = 4'b0000;
    illegal = 1'b0;
    case (HSIZE)
      3'd0: mask = 4'b0001 << HADDR[1:0];
      3'd1: begin
        mask    = HADDR[1] ? 4'b1100 : 4'b0011;
        illegal = HADDR[0];
      end
      3'd2: begin
        mask    = 4'b1111;
        illegal = (HADDR[1:0] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clka) begin
    if (rst) begin
      state   <= RESP_OKAY;
      wr_dp   <= 1'b0;
      rd_dp   <= 1'b0;
      fwd     <= 1'b0;
      wr_addr <= '0;
      wr_mask <= 4'b0000;
    end else begin
      state <= state_nxt;
      wr_dp <= acc_wr;
      rd_dp <= acc_rd;
      // The RAM returns pre-write data for a read issued while the write commits.
      fwd   <= acc_rd & wr_dp & (wr_addr == haddr_word);
      if (acc_wr) begin
        wr_addr <= haddr_word;
        wr_mask <= mask;
      end
    end
  end

  // NOTE: forwarding payload registers need no reset; they are only observed while fwd is set.
  always_ff @(posedge clka) begin
    if (acc_rd) begin
      fwd_data <= HWDATA;
      fwd_mask <= wr_mask;
    end
  end

  always_comb begin
    state_nxt = state;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      RESP_OKAY: if (accept && illegal) state_nxt = RESP_ERR1;
      RESP_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = RESP_ERR2;
      end
      RESP_ERR2: begin
        HRESP     = 1'b1;
        state_nxt = (accept && illegal) ? RESP_ERR1 : RESP_OKAY;
      end
      default: state_nxt = RESP_OKAY;
    endcase
  end

  always_comb begin
    HRDATA = 32'h0;
    if (rd_dp) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (fwd && fwd_mask[i]) ? fwd_data[8*i +: 8] : doutb[8*i +: 8];
      end
    end
  end

  // A write still in its data phase when reset arrives is dropped.
  assign wea   = (wr_dp && !rst) ? wr_mask : 4'b0000;
  assign addra = wr_addr;
  assign dina  = HWDATA;
  assign addrb = haddr_word;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Scoreboard bench for ahb_bram_ctrl: a byte-level reference memory predicts every data phase,
// and a bus monitor pops and compares whenever it observes a transfer's data phase.
module tb_ahb_bram_ctrl;
  localparam int AW = 12;

  logic          clka = 1'b0;
  logic          rst;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] addra;
  logic [31:0]   dina;
  logic [3:0]    wea;
  logic [AW-1:0] addrb;
  logic [31:0]   doutb;

  logic          hready_force;
  logic          ram_clr;

  assign HREADY = HREADYOUT & hready_force;

  always #5 clka = ~clka;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clka(clka), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .addra(addra), .dina(dina), .wea(wea), .addrb(addrb), .doutb(doutb)
  );

  // Block RAM: registered read, read-before-write on a same-address collision.
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clka) begin
    if (ram_clr) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= 32'h0;
      doutb <= 32'h0;
    end else begin
      doutb <= ram[addrb];
      for (int i = 0; i < 4; i++) if (wea[i]) ram[addra][8*i +: 8] <= dina[8*i +: 8];
    end
  end

  typedef enum {K_WR, K_RD, K_ERR} kind_t;
  typedef struct {
    kind_t       kind;
    int          addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_bytes [0:(4<<AW)-1];
  logic [31:0] next_wdata;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one address phase (plus the previous write's data) and predict its data phase.
  task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic hrdy, input logic drop,
                       output logic was_err);
    exp_t e;
    int   nbytes, off, word;
    logic bad;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
    HWDATA = next_wdata; hready_force = hrdy;
    next_wdata = $urandom;
    was_err = 1'b0;
    if (sel && trans[1] && hrdy) begin
      nbytes = 1 << size;
      off    = int'(addr[1:0]);
      word   = int'(addr[AW+1:2]);
      bad    = (size > 3'd2) || ((off % nbytes) != 0);
      e.addr = word;
      e.mask = 4'b0000;
      e.data = 32'h0;
      if (bad) begin
        e.kind  = K_ERR;
        was_err = 1'b1;
      end else begin
        for (int b = 0; b < 4; b++) e.mask[b] = (b >= off) && (b < off + nbytes);
        if (wr) begin
          e.kind     = K_WR;
          e.data     = wdata;
          next_wdata = wdata;
          if (drop) e.mask = 4'b0000;
          for (int b = 0; b < 4; b++)
            if (e.mask[b]) ref_bytes[word*4 + b] = wdata[8*b +: 8];
        end else begin
          e.kind = K_RD;
          for (int b = 0; b < 4; b++) e.data[8*b +: 8] = ref_bytes[word*4 + b];
        end
      end
      exp_q.push_back(e);
    end
    @(posedge clka); #1;
  endtask

  task automatic idle();
    logic dummy;
    issue(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0, dummy);
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic drop = 1'b0);
    logic was_err;
    issue(1'b1, 2'b10, wr, addr, size, wdata, 1'b1, drop, was_err);
    if (was_err) begin idle(); idle(); end
  endtask

  // Monitor: a transfer seen on the bus at an edge has its data phase in the following cycle.
  initial begin : monitor
    exp_t e;
    logic acc;
    logic err2 = 1'b0;
    forever begin
      @(posedge clka);
      acc = HSEL && HTRANS[1] && HREADY && !rst;
      @(negedge clka);
      if (err2) begin
        check("err2 hreadyout", HREADYOUT, 1);
        check("err2 hresp", HRESP, 1);
        check("err2 wea", wea, 0);
        err2 = 1'b0;
      end else if (acc) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard: unpredicted transfer at t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          case (e.kind)
            K_WR: begin
              check("write wea", wea, e.mask);
              if (e.mask != 0) begin
                check("write addra", addra, e.addr);
                check("write dina", dina, e.data);
              end
              check("write hrdata", HRDATA, 0);
              check("write hreadyout", HREADYOUT, 1);
              check("write hresp", HRESP, 0);
            end
            K_RD: begin
              check("read hrdata", HRDATA, e.data);
              check("read wea", wea, 0);
              check("read hreadyout", HREADYOUT, 1);
              check("read hresp", HRESP, 0);
            end
            default: begin
              check("err1 hreadyout", HREADYOUT, 0);
              check("err1 hresp", HRESP, 1);
              check("err1 wea", wea, 0);
              check("err1 hrdata", HRDATA, 0);
              err2 = 1'b1;
            end
          endcase
        end
      end else begin
        check("idle wea", wea, 0);
        check("idle hrdata", HRDATA, 0);
        check("idle hreadyout", HREADYOUT, 1);
        check("idle hresp", HRESP, 0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic        was_err;
    logic        sel, wr, hrdy;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    int          r;

    for (int i = 0; i < (4 << AW); i++) ref_bytes[i] = 8'h0;
    rst = 1'b1; ram_clr = 1'b1; hready_force = 1'b1; next_wdata = 32'h0;
    HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HSIZE = 3'd0; HWRITE = 1'b0; HWDATA = 32'h0;
    repeat (3) @(posedge clka);
    #1;
    rst = 1'b0; ram_clr = 1'b0;
    check("reset hreadyout", HREADYOUT, 1);
    check("reset hresp", HRESP, 0);
    check("reset wea", wea, 0);
    check("reset hrdata", HRDATA, 0);
    check("reset addra", addra, 0);

    // Word write then read back.
    xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    xfer(1'b0, 32'h10, 3'd2, 32'h0);
    // Byte lanes, final read forwards lane 3.
    xfer(1'b1, 32'h20, 3'd0, 32'h0000_0011);
    xfer(1'b1, 32'h21, 3'd0, 32'h0000_2200);
    xfer(1'b1, 32'h22, 3'd0, 32'h0033_0000);
    xfer(1'b1, 32'h23, 3'd0, 32'h4400_0000);
    xfer(1'b0, 32'h20, 3'd2, 32'h0);
    idle();
    // Half write forwarded into back-to-back read; different word is not forwarded.
    xfer(1'b1, 32'h20, 3'd2, 32'h0000_0000);
    idle();
    xfer(1'b1, 32'h22, 3'd1, 32'hABCD_0000);
    xfer(1'b0, 32'h20, 3'd2, 32'h0);
    xfer(1'b1, 32'h24, 3'd2, 32'h5555_AAAA);
    xfer(1'b0, 32'h20, 3'd2, 32'h0);
    // Illegal transfers leave memory untouched.
    xfer(1'b1, 32'h31, 3'd2, 32'hFFFF_FFFF);
    xfer(1'b1, 32'h30, 3'd3, 32'hFFFF_FFFF);
    xfer(1'b1, 32'h33, 3'd1, 32'hFFFF_FFFF);
    xfer(1'b0, 32'h30, 3'd2, 32'h0);
    // Reset during a write data phase drops the write.
    xfer(1'b1, 32'h40, 3'd2, 32'h1234_5678);
    idle();
    xfer(1'b1, 32'h40, 3'd2, 32'hCAFE_F00D, 1'b1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    xfer(1'b0, 32'h40, 3'd2, 32'h0);
    // Transfers that must not be acted on.
    issue(1'b1, 2'b00, 1'b1, 32'h50, 3'd2, 32'h1111_1111, 1'b1, 1'b0, was_err);
    issue(1'b1, 2'b01, 1'b1, 32'h50, 3'd2, 32'h2222_2222, 1'b1, 1'b0, was_err);
    issue(1'b0, 2'b10, 1'b1, 32'h50, 3'd2, 32'h3333_3333, 1'b1, 1'b0, was_err);
    issue(1'b1, 2'b10, 1'b1, 32'h50, 3'd2, 32'h4444_4444, 1'b0, 1'b0, was_err);
    idle();
    xfer(1'b0, 32'h50, 3'd2, 32'h0);

    // Randomized traffic over a small window to provoke forwarding collisions.
    for (int n = 0; n < 500; n++) begin
      sel   = ($urandom_range(0, 99) >= 8);
      trans = {($urandom_range(0, 9) >= 2), 1'($urandom)};
      hrdy  = ($urandom_range(0, 9) != 0);
      wr    = 1'($urandom);
      addr  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
      r     = $urandom_range(0, 19);
      size  = (r < 18) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      issue(sel, trans, wr, addr, size, $urandom, hrdy, 1'b0, was_err);
      if (was_err) begin idle(); idle(); end
    end

    repeat (3) idle();
    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
